melody_sequencer: RTL

- Upstream driver for the per-note square-wave tone generators. Each generator takes a 1-bit switch enable plus clk and drives the speaker.
- Debounces a raw play button and steps through a fixed 16-step melody ROM.
- Each step asserts one bit of a one-hot note_en bus for a set number of beats, followed by a short silent gap. The note_en bits wire directly to the generators' switch inputs.

---
 rtl/melody_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/melody_sequencer.sv
// Debounced play/stop control stepping a fixed 16-step melody ROM.
// Drives a one-hot note enable bus for downstream tone generators.
module melody_sequencer #(
  parameter int unsigned NUM_NOTES   = 8,
  parameter int unsigned BEAT_CYCLES = 5000000,
  parameter int unsigned GAP_CYCLES  = 400000,
  parameter int unsigned DEB_CYCLES  = 200000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 play_btn_i,
  input  logic                 loop_en_i,
  output logic [NUM_NOTES-1:0] note_en_o,
  output logic                 busy_o,
  output logic [3:0]           step_idx_o,
  output logic                 song_done_o
);

  localparam int unsigned DurMax = (2 * BEAT_CYCLES > GAP_CYCLES) ? 2 * BEAT_CYCLES : GAP_CYCLES;
  localparam int unsigned DurW   = (DurMax > 1) ? $clog2(DurMax) : 1;
  localparam int unsigned DebW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e                 state_q;
  logic                   sync1_q, sync2_q;
  logic                   deb_level_q;
  logic [DebW-1:0]        deb_cnt_q;
  logic                   play_pulse_q;
  logic [DurW-1:0]        dur_q;
  logic [3:0]             step_q;
  logic [NUM_NOTES-1:0]   note_q;
  logic                   song_done_q;

  logic [5:0]             rom_cur, rom_nxt;
  logic [3:0]             step_nxt;
  logic [DurW-1:0]        play_last;

  // Entry = {code[3:0], beats_m1[1:0]}; codes 8..15 are rests.
  function automatic logic [5:0] rom_entry(input logic [3:0] idx);
    logic [3:0] code;
    logic [1:0] beats_m1;
    if (idx < 4'd8)       code = idx;
    else if (idx < 4'd15) code = 4'd14 - idx;
    else                  code = 4'd15;
    beats_m1 = (idx == 4'd7 || idx == 4'd15) ? 2'd1 : 2'd0;
    return {code, beats_m1};
  endfunction

  function automatic logic [NUM_NOTES-1:0] note_of(input logic [5:0] entry);
    logic [NUM_NOTES-1:0] r;
    r = '0;
    if (entry[5:2] < 4'd8 && 32'(entry[5:2]) < NUM_NOTES) begin
      r = {{(NUM_NOTES-1){1'b0}}, 1'b1} << entry[5:2];
    end
    return r;
  endfunction

  // Wraps 15 -> 0, which is exactly the loop-restart step.
  assign step_nxt  = step_q + 4'd1;
  assign rom_cur   = rom_entry(step_q);
  assign rom_nxt   = rom_entry(step_nxt);
  assign play_last = DurW'((32'(rom_cur[1:0]) + 32'd1) * BEAT_CYCLES - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      deb_level_q  <= 1'b0;
      deb_cnt_q    <= '0;
      play_pulse_q <= 1'b0;
    end else begin
      sync1_q      <= play_btn_i;
      sync2_q      <= sync1_q;
      play_pulse_q <= 1'b0;
      if (sync2_q != deb_level_q) begin
        if (deb_cnt_q == DebW'(DEB_CYCLES - 1)) begin
          deb_level_q  <= sync2_q;
          deb_cnt_q    <= '0;
          play_pulse_q <= sync2_q;
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dur_q       <= '0;
      step_q      <= 4'd0;
      note_q      <= '0;
      song_done_q <= 1'b0;
    end else begin
      song_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (play_pulse_q) begin
            state_q <= StPlay;
            step_q  <= 4'd0;
            dur_q   <= '0;
            note_q  <= note_of(rom_entry(4'd0));
          end
        end
        StPlay, StGap: begin
          // A press while busy stops, and takes priority over any step change.
          if (play_pulse_q) begin
            state_q <= StIdle;
            step_q  <= 4'd0;
            dur_q   <= '0;
            note_q  <= '0;
          end else if (state_q == StPlay) begin
            if (dur_q == play_last) begin
              state_q <= StGap;
              dur_q   <= '0;
              note_q  <= '0;
            end else begin
              dur_q <= dur_q + 1'b1;
            end
          end else if (dur_q == DurW'(GAP_CYCLES - 1)) begin
            dur_q <= '0;
            if (step_q != 4'd15 || loop_en_i) begin
              state_q <= StPlay;
              step_q  <= step_nxt;
              note_q  <= note_of(rom_nxt);
            end else begin
              state_q     <= StIdle;
              step_q      <= 4'd0;
              song_done_q <= 1'b1;
            end
          end else begin
            dur_q <= dur_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          dur_q   <= '0;
          step_q  <= 4'd0;
          note_q  <= '0;
        end
      endcase
    end
  end

  assign note_en_o   = note_q;
  assign busy_o      = (state_q != StIdle);
  assign step_idx_o  = step_q;
  assign song_done_o = song_done_q;

endmodule
